// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM host arbiter.
// Holds the arbiter state encoding and the default parameter values.
package sdram_arb_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_ADDR_W    = 24;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_TIMEOUT   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sdram_rr_select.sv
// Combinational round-robin selector.
// Ports:
//   req    - request vector, one bit per port
//   ptr    - port at which the search starts (highest priority)
//   winner - first requesting port found from ptr upward, wrapping
//   valid  - at least one request is present
module sdram_rr_select
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     winner,
  output logic                 valid
);

  logic [IDX_W:0] idx;

  // Walk from the farthest offset back to ptr so the closest requester
  // (in wrap-around order) is the one left standing.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (idx >= (IDX_W + 1)'(NUM_PORTS)) begin
        idx = idx - (IDX_W + 1)'(NUM_PORTS);
      end
      if (req[idx[IDX_W-1:0]]) begin
        winner = idx[IDX_W-1:0];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter funnelling NUM_PORTS requesters into a single SDRAM
// controller host interface, one transfer at a time.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   p_req/p_rw         - per-port request level and direction (1=write)
//   p_addr/p_wdata     - flattened per-port address / write data
//   p_ack/p_rdata      - one-cycle completion pulse and read data
//   host_req/rw/addr/wdata - request towards the controller
//   host_busy/host_rdata   - controller busy flag and read data
//   timeout_err        - sticky flag, set when the controller stays busy
//                        for TIMEOUT wait cycles
module sdram_host_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        p_req,
  input  logic [NUM_PORTS-1:0]        p_rw,
  input  logic [NUM_PORTS*ADDR_W-1:0] p_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
  output logic [NUM_PORTS-1:0]        p_ack,
  output logic [DATA_W-1:0]           p_rdata,
  output logic                        host_req,
  output logic                        host_rw,
  output logic [ADDR_W-1:0]           host_addr,
  output logic [DATA_W-1:0]           host_wdata,
  input  logic                        host_busy,
  input  logic [DATA_W-1:0]           host_rdata,
  output logic                        timeout_err
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_vld;
  logic [CNT_W-1:0] wait_cnt;
  logic             lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic             wait_exit;
  logic             wait_expired;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_PORTS - 1)) begin
      return '0;
    end
    return idx + IDX_W'(1);
  endfunction

  sdram_rr_select #(
    .NUM_PORTS(NUM_PORTS)
  ) u_rr_select (
    .req   (p_req),
    .ptr   (rr_ptr),
    .winner(sel_idx),
    .valid (sel_vld)
  );

  // The latches are cleared on the way back to IDLE, so driving the host
  // fields straight from them gives zeros while idle and stable values
  // from ISSUE through DONE.
  assign host_rw    = lat_rw;
  assign host_addr  = lat_addr;
  assign host_wdata = lat_wdata;

  assign wait_expired = host_busy && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign wait_exit    = !host_busy || wait_expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      winner      <= '0;
      wait_cnt    <= '0;
      lat_rw      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      host_req    <= 1'b0;
      p_ack       <= '0;
      p_rdata     <= '0;
      timeout_err <= 1'b0;
    end else begin
      host_req <= 1'b0;
      p_ack    <= '0;
      case (state)
        // Grant: capture the winner's request so later p_req changes
        // cannot disturb the transfer.
        IDLE: begin
          if (sel_vld && !host_busy) begin
            winner    <= sel_idx;
            lat_rw    <= p_rw[sel_idx];
            lat_addr  <= p_addr[sel_idx*ADDR_W +: ADDR_W];
            lat_wdata <= p_wdata[sel_idx*DATA_W +: DATA_W];
            host_req  <= 1'b1;
            state     <= ISSUE;
          end
        end
        // Issue: host_req has been high for this single cycle.
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        // Wait: completion or timeout both lead to an ack.
        WAIT: begin
          if (wait_exit) begin
            if (wait_expired) begin
              timeout_err <= 1'b1;
            end
            p_ack   <= NUM_PORTS'(1) << winner;
            p_rdata <= lat_rw ? '0 : host_rdata;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        // Done: ack is visible this cycle; advance the pointer past the
        // winner and clear the host fields for IDLE.
        DONE: begin
          rr_ptr    <= next_ptr(winner);
          wait_cnt  <= '0;
          lat_rw    <= 1'b0;
          lat_addr  <= '0;
          lat_wdata <= '0;
          p_rdata   <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed bench for sdram_host_arbiter with a small controller model.
module tb_sdram_host_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   p_req;
  logic [3:0]   p_rw;
  logic [95:0]  p_addr;
  logic [127:0] p_wdata;
  logic [3:0]   p_ack;
  logic [31:0]  p_rdata;
  logic         host_req;
  logic         host_rw;
  logic [23:0]  host_addr;
  logic [31:0]  host_wdata;
  logic         host_busy;
  logic [31:0]  host_rdata;
  logic         timeout_err;

  int checks = 0;
  int errors = 0;

  // controller model controls
  int unsigned busy_len = 0;
  logic [31:0] model_rdata = '0;
  bit          sticky = 0;
  int unsigned bcnt;

  typedef struct {
    int          port;
    bit          rw;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned blen;
    logic [3:0]  exp_ack;
    logic [31:0] exp_rd;
    int          exp_ptr;
  } txn_t;

  txn_t vec[4];
  int   order[5];
  int   exp_order[5];

  sdram_host_arbiter #(
    .NUM_PORTS(4), .ADDR_W(24), .DATA_W(32), .TIMEOUT(64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_req      (p_req),
    .p_rw       (p_rw),
    .p_addr     (p_addr),
    .p_wdata    (p_wdata),
    .p_ack      (p_ack),
    .p_rdata    (p_rdata),
    .host_req   (host_req),
    .host_rw    (host_rw),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_busy  (host_busy),
    .host_rdata (host_rdata),
    .timeout_err(timeout_err)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Controller: busy for busy_len cycles after seeing host_req, then
  // presents registered read data; sticky keeps it busy indefinitely.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      host_busy  <= 1'b0;
      host_rdata <= '0;
      bcnt       <= 0;
    end else if (host_req) begin
      if (sticky) begin
        host_busy <= 1'b1;
        bcnt      <= 1;
      end else if (busy_len != 0) begin
        host_busy <= 1'b1;
        bcnt      <= busy_len;
      end else begin
        host_rdata <= model_rdata;
      end
    end else if (host_busy && !sticky) begin
      if (bcnt <= 1) begin
        host_busy  <= 1'b0;
        host_rdata <= model_rdata;
        bcnt       <= 0;
      end else begin
        bcnt <= bcnt - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output logic [3:0] ack, output bit got);
    int cyc;
    cyc = 0;
    got = 0;
    ack = '0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (p_ack != 0) begin
        got = 1;
        ack = p_ack;
      end
    end
  endtask

  task automatic wait_host_req(input int budget, output bit got);
    int cyc;
    cyc = 0;
    got = 0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (host_req) got = 1;
    end
  endtask

  task automatic run_txn(input txn_t t);
    int hreq_cnt;
    int cyc;
    bit seen;
    bit unstable;
    bit got;
    hreq_cnt = 0; cyc = 0; seen = 0; unstable = 0; got = 0;
    @(negedge clk);
    busy_len = t.blen;
    model_rdata = t.rdata;
    p_rw[t.port] = t.rw;
    p_addr[t.port*24 +: 24] = t.addr;
    p_wdata[t.port*32 +: 32] = t.wdata;
    p_req[t.port] = 1'b1;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (host_req) begin
        hreq_cnt++;
        seen = 1;
      end
      if (seen && (host_addr !== t.addr || host_wdata !== t.wdata || host_rw !== t.rw))
        unstable = 1;
      if (p_ack != 0) got = 1;
    end
    p_req[t.port] = 1'b0;
    chk("ack_seen", 64'(got), 64'd1);
    chk("ack_vec", 64'(p_ack), 64'(t.exp_ack));
    chk("ack_rdata", 64'(p_rdata), 64'(t.exp_rd));
    chk("host_req_pulses", 64'(hreq_cnt), 64'd1);
    chk("host_fields_stable", 64'(unstable), 64'd0);
    @(negedge clk);
    chk("rr_ptr", 64'(dut.rr_ptr), 64'(t.exp_ptr));
    chk("ack_cleared", 64'(p_ack), 64'd0);
    chk("idle_host_fields", {31'd0, host_rw, host_addr, host_wdata[7:0]}, 64'd0);
  endtask

  initial begin
    logic [3:0] ack;
    bit got;
    bit multi;
    int n;
    int cyc;
    bit prev_err;

    rst = 1'b1;
    p_req = '0; p_rw = '0; p_addr = '0; p_wdata = '0;

    vec[0] = '{port: 2, rw: 1'b0, addr: 24'h123456, wdata: 32'h0, rdata: 32'hDEADBEEF,
               blen: 10, exp_ack: 4'b0100, exp_rd: 32'hDEADBEEF, exp_ptr: 3};
    vec[1] = '{port: 1, rw: 1'b1, addr: 24'hABCDEF, wdata: 32'hA5A5A5A5, rdata: 32'h11111111,
               blen: 3, exp_ack: 4'b0010, exp_rd: 32'h0, exp_ptr: 2};
    vec[2] = '{port: 3, rw: 1'b0, addr: 24'h000001, wdata: 32'h0, rdata: 32'h0BADF00D,
               blen: 0, exp_ack: 4'b1000, exp_rd: 32'h0BADF00D, exp_ptr: 0};
    vec[3] = '{port: 0, rw: 1'b1, addr: 24'hFFFFFF, wdata: 32'hFFFFFFFF, rdata: 32'h22222222,
               blen: 1, exp_ack: 4'b0001, exp_rd: 32'h0, exp_ptr: 1};

    do_reset();
    #1;
    chk("reset_outputs", {p_ack, host_req, host_rw, host_addr, p_rdata[3:0], timeout_err}, 64'd0);
    chk("reset_wdata_rdata", {host_wdata, p_rdata}, 64'd0);
    chk("reset_state", {dut.state, dut.rr_ptr, dut.winner, dut.wait_cnt}, 64'd0);

    for (int i = 0; i < 4; i++) run_txn(vec[i]);

    // all ports requesting continuously from reset
    do_reset();
    busy_len = 2;
    p_rw = '0;
    p_req = 4'hF;
    exp_order = '{0, 1, 2, 3, 0};
    n = 0; cyc = 0; multi = 0;
    while (n < 5 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (p_ack != 0) begin
        if (!$onehot(p_ack)) multi = 1;
        order[n] = idx_of(p_ack);
        n++;
      end
    end
    p_req = '0;
    chk("rr_grant_count", 64'(n), 64'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 64'(order[i]), 64'(exp_order[i]));
    chk("rr_onehot", 64'(multi), 64'd0);

    // reset during WAIT: transfer dropped, pointer back to 0
    do_reset();
    run_txn(vec[1]);
    @(negedge clk);
    busy_len = 20;
    p_rw[1] = 1'b0;
    p_req[1] = 1'b1;
    wait_host_req(20, got);
    chk("midrst_issue_seen", 64'(got), 64'd1);
    repeat (3) @(negedge clk);
    chk("midrst_in_wait", 64'(dut.state), 64'd2);
    rst = 1'b1;
    p_req = '0;
    #1;
    chk("midrst_outputs_zero", {p_ack, host_req, host_rw, host_addr, timeout_err}, 64'd0);
    chk("midrst_data_zero", {host_wdata, p_rdata}, 64'd0);
    chk("midrst_ptr", 64'(dut.rr_ptr), 64'd0);
    got = 0;
    repeat (3) begin
      @(negedge clk);
      if (p_ack != 0) got = 1;
    end
    chk("midrst_no_ack", 64'(got), 64'd0);
    rst = 1'b0;
    busy_len = 2;
    p_req = 4'b1010;
    wait_ack(100, ack, got);
    p_req = '0;
    chk("post_rst_grant", 64'(ack), 64'b0010);

    // port 0 held after its ack while port 3 waits: port 3 goes next
    do_reset();
    @(negedge clk);
    p_req = 4'b0001;
    wait_host_req(20, got);
    p_req = 4'b1001;
    wait_ack(100, ack, got);
    chk("held_first_ack", 64'(ack), 64'b0001);
    wait_ack(100, ack, got);
    p_req = '0;
    chk("held_second_ack", 64'(ack), 64'b1000);

    // controller stuck busy: timeout after 64 WAIT cycles, ack still given
    do_reset();
    @(negedge clk);
    sticky = 1;
    p_rw[2] = 1'b0;
    p_req[2] = 1'b1;
    wait_host_req(20, got);
    chk("to_issue_seen", 64'(got), 64'd1);
    n = 0; got = 0; prev_err = 1;
    while (!got && n < 200) begin
      prev_err = timeout_err;
      @(negedge clk);
      n++;
      if (p_ack != 0) got = 1;
    end
    p_req = '0;
    chk("to_cycles_to_ack", 64'(n), 64'd65);
    chk("to_ack", 64'(p_ack), 64'b0100);
    chk("to_err_before", 64'(prev_err), 64'd0);
    chk("to_err_set", 64'(timeout_err), 64'd1);
    repeat (30) @(negedge clk);
    chk("to_err_sticky", 64'(timeout_err), 64'd1);
    sticky = 0;
    repeat (3) @(negedge clk);
    run_txn(vec[3]);
    chk("to_err_after_txn", 64'(timeout_err), 64'd1);
    do_reset();
    #1;
    chk("to_err_cleared", 64'(timeout_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_host_arbiter.md
SDRAM_HOST_ARBITER -- requirements
Module: sdram_host_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4, SHALL set the number of requester ports (2..8).
REQ-002 Parameter ADDR_W, default 24, SHALL set the host address width.
REQ-003 Parameter DATA_W, default 32, SHALL set the host data width.
REQ-004 Parameter TIMEOUT, default 64, SHALL set the maximum number of WAIT cycles before the error flag is set.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: clk, input, 1, rising-edge clock; rst, input, 1, asynchronous active-high reset.
REQ-006 p_req, input, NUM_PORTS: per-port request, level, held high until p_ack.
REQ-007 p_rw, input, NUM_PORTS: per-port direction, 1=write, 0=read.
REQ-008 p_addr, input, NUM_PORTS*ADDR_W: flattened per-port address, port i at [i*ADDR_W +: ADDR_W].
REQ-009 p_wdata, input, NUM_PORTS*DATA_W: flattened per-port write data.
REQ-010 p_ack, output, NUM_PORTS: one-cycle completion pulse to the granted port.
REQ-011 p_rdata, output, DATA_W: read data, valid in the p_ack cycle of a read.
REQ-012 host_req, host_rw, host_addr[ADDR_W], host_wdata[DATA_W], all outputs: the controller host request fields.
REQ-013 host_busy, input, 1, and host_rdata, input, DATA_W: controller busy and registered read data.
REQ-014 timeout_err, output, 1: sticky flag indicating a WAIT timeout.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-016 IDLE: when any p_req is high and host_busy=0, the FSM SHALL select the winner by round-robin from the pointer rr_ptr, latch the winner index, rw, addr and wdata, and go to ISSUE.
REQ-017 Round-robin: the search SHALL start at rr_ptr and wrap modulo NUM_PORTS; a single requester SHALL win immediately regardless of rr_ptr.
REQ-018 ISSUE: host_req SHALL be 1 for exactly one cycle, then the FSM SHALL go to WAIT.
REQ-019 host_rw, host_addr and host_wdata SHALL be driven from the latched registers and held stable from ISSUE through DONE; they SHALL be 0 in IDLE.
REQ-020 WAIT: host_req SHALL be 0, and the FSM SHALL go to DONE on the first cycle with host_busy=0.
REQ-021 WAIT SHALL count cycles; if the count reaches TIMEOUT, timeout_err SHALL be set, the FSM SHALL go to DONE, and the ack SHALL still be issued.
REQ-022 DONE: p_ack[winner] SHALL be 1 for one cycle, p_rdata SHALL equal host_rdata (0 for a write), rr_ptr SHALL become (winner+1) mod NUM_PORTS, and the FSM SHALL return to IDLE.
REQ-023 Latency SHALL be 1 cycle (IDLE) + 1 (ISSUE) + the controller busy time + 1 (DONE) from the request seen to p_ack.
REQ-024 A p_req still high in the cycle after p_ack SHALL be treated as a new request.
REQ-025 A p_req change during ISSUE, WAIT or DONE SHALL NOT affect the transfer in flight.
REQ-026 A port that deasserts p_req before it is granted SHALL NOT be served.
REQ-027 Exactly one p_ack bit or none SHALL be high in any cycle.
REQ-028 timeout_err SHALL be cleared only by reset.

Reset
REQ-029 On rst the block SHALL set: state IDLE, rr_ptr 0, wait counter 0, winner 0, all latches 0, host_req 0, host_rw 0, host_addr 0, host_wdata 0, p_ack 0, p_rdata 0, timeout_err 0.
REQ-030 Reset mid-transfer SHALL drop the transfer with no ack, and host_req SHALL be 0 from the reset edge onward.

Structure
REQ-031 Package sdram_arb_pkg SHALL hold the state enum arb_state_t and the default parameter constants.
REQ-032 Sub-module sdram_rr_select SHALL be purely combinational: inputs request vector and pointer; outputs the winner index and a valid bit.

Verification
REQ-033 Single port 2 read, addr 0x123456, controller model busy for 10 cycles returning 0xDEADBEEF -> host_req high for one cycle, p_ack[2] high for one cycle, p_rdata=0xDEADBEEF, rr_ptr=3.
REQ-034 All 4 ports request continuously from reset -> grants in order 0,1,2,3,0 with no port granted twice before the others.
REQ-035 Port 1 write, wdata 0xA5A5A5A5 -> host_addr and host_wdata stable from ISSUE through DONE, host_rw=1, p_rdata=0 at ack.
REQ-036 host_busy held high for 100 cycles -> timeout_err=1 at WAIT cycle 64, ack still issued, flag stays 1 until rst.
REQ-037 rst asserted during WAIT -> no p_ack, all outputs 0 immediately, and the next request is granted from rr_ptr=0.
REQ-038 Port 0 request held in the cycle after its ack while port 3 is also requesting -> port 3 is served next.
